// File: rtl/instruction_decode.sv
// MIPS32 decode stage: IF/ID register, 32x32 register file with write-through
// bypass, field decode, load-use stall detection and the ID/EX register.
module instruction_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic        load_mem_en,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_rs_addr,
  output logic [4:0]  ex_rt_addr,
  output logic [4:0]  ex_dst_addr,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_branch,
  output logic        ex_bne,
  output logic        ex_jump,
  output logic [31:0] ex_jump_target,
  output logic        ex_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_SUB      = 4'd1,
    ALU_AND      = 4'd2,
    ALU_OR       = 4'd3,
    ALU_SLT      = 4'd4,
    ALU_SLL      = 4'd5,
    ALU_SRL      = 4'd6,
    ALU_PASS_IMM = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] jump_target;
    logic [4:0]  shamt;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dst_addr;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        bne;
    logic        jump;
    logic        illegal;
  } idex_t;

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] regs_q [32];
  idex_t       idex_q, idex_d, dec;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] imm_sext, imm_zext;
  logic [31:0] rs_data, rt_data;
  logic        uses_rs, uses_rt, illegal;

  assign op       = ifid_instr_q[31:26];
  assign rs       = ifid_instr_q[25:21];
  assign rt       = ifid_instr_q[20:16];
  assign rd       = ifid_instr_q[15:11];
  assign funct    = ifid_instr_q[5:0];
  assign imm16    = ifid_instr_q[15:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0, imm16};

  // NOTE: the register file is reset entry by entry, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale operand.
  always_comb begin
    rs_data = regs_q[rs];
    rt_data = regs_q[rt];
    if (rs == 5'd0)                     rs_data = '0;
    else if (wb_en && wb_addr == rs)    rs_data = wb_data;
    if (rt == 5'd0)                     rt_data = '0;
    else if (wb_en && wb_addr == rt)    rt_data = wb_data;
  end

  // NOTE: every field gets a default before the case, so no latch can be inferred.
  always_comb begin
    dec             = '0;
    illegal         = 1'b0;
    dec.pc          = ifid_pc_q;
    dec.rs_addr     = rs;
    dec.rt_addr     = rt;
    dec.rs_data     = rs_data;
    dec.rt_data     = rt_data;
    dec.shamt       = ifid_instr_q[10:6];
    dec.jump_target = {ifid_pc_q[31:28], ifid_instr_q[25:0], 2'b00};
    case (op)
      OP_RTYPE: begin
        dec.dst_addr  = rd;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_SLL:  dec.alu_op = ALU_SLL;
          FN_SRL:  dec.alu_op = ALU_SRL;
          default: illegal    = 1'b1;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: begin
        dec.dst_addr  = rt;
        dec.alu_src   = 1'b1;
        dec.reg_write = (op != OP_SW);
        dec.imm       = imm_sext;
        dec.alu_op    = ALU_ADD;
        case (op)
          OP_ANDI: begin dec.alu_op = ALU_AND; dec.imm = imm_zext; end
          OP_ORI:  begin dec.alu_op = ALU_OR;  dec.imm = imm_zext; end
          OP_LUI:  begin dec.alu_op = ALU_PASS_IMM; dec.imm = {imm16, 16'h0}; end
          OP_LW:   begin dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; end
          OP_SW:   dec.mem_write = 1'b1;
          default: ;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
        dec.bne    = (op == OP_BNE);
        dec.imm    = imm_sext;
      end
      OP_J:    dec.jump = 1'b1;
      default: illegal  = 1'b1;
    endcase
    if (illegal) begin
      dec.alu_op     = ALU_ADD;
      dec.alu_src    = 1'b0;
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.dst_addr   = '0;
      dec.illegal    = 1'b1;
    end
    // Writes to $0 are architecturally void; dropping them here makes NOP inert.
    if (dec.dst_addr == 5'd0) dec.reg_write = 1'b0;
  end

  assign uses_rs = !(op == OP_J || op == OP_LUI);
  assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  assign stall   = idex_q.mem_read && (idex_q.dst_addr != 5'd0) &&
                   ((idex_q.dst_addr == rs && uses_rs) || (idex_q.dst_addr == rt && uses_rt));

  // Program load outranks a stall: the pipe is flushed to NOPs and bubbles.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    if (load_mem_en) begin
      ifid_instr_d = '0;
      ifid_pc_d    = '0;
    end else if (!stall) begin
      ifid_instr_d = instr;
      ifid_pc_d    = pc_in;
    end
    idex_d = (stall || load_mem_en) ? '0 : dec;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      idex_q       <= '0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      idex_q       <= idex_d;
    end
  end

  assign ex_pc          = idex_q.pc;
  assign ex_rs_data     = idex_q.rs_data;
  assign ex_rt_data     = idex_q.rt_data;
  assign ex_imm         = idex_q.imm;
  assign ex_shamt       = idex_q.shamt;
  assign ex_rs_addr     = idex_q.rs_addr;
  assign ex_rt_addr     = idex_q.rt_addr;
  assign ex_dst_addr    = idex_q.dst_addr;
  assign ex_alu_op      = idex_q.alu_op;
  assign ex_alu_src     = idex_q.alu_src;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_mem_to_reg  = idex_q.mem_to_reg;
  assign ex_branch      = idex_q.branch;
  assign ex_bne         = idex_q.bne;
  assign ex_jump        = idex_q.jump;
  assign ex_jump_target = idex_q.jump_target;
  assign ex_illegal     = idex_q.illegal;

endmodule
